// File: rtl/frame_blitter.sv
// Full-frame image blitter: scans a raster, addresses a bank of image ROMs
// and plots the selected image, realigning ROM data with pixel coordinates.
module frame_blitter #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int XW         = 8,
    parameter int YW         = 7,
    parameter int AW         = 15,
    parameter int CW         = 3,
    parameter int NIMG       = 7,
    parameter int SELW       = 3,
    parameter int ROM_LAT    = 1,
    parameter int CONTINUOUS = 0,
    parameter int KEY_COLOUR = 0
) (
    input  logic                 iClock,
    input  logic                 iReset,
    input  logic                 iStart,
    input  logic [SELW-1:0]      iSel,
    input  logic                 iKeyEn,
    input  logic [NIMG*CW-1:0]   iRomData,
    output logic [AW-1:0]        oAddr,
    output logic [XW-1:0]        oX,
    output logic [YW-1:0]        oY,
    output logic [CW-1:0]        oColour,
    output logic                 oPlot,
    output logic                 oBusy,
    output logic                 oDone
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);
    localparam int            DW   = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [DW-1:0] DMAX = DW'(ROM_LAT - 1);

    state_t           state, state_d;
    logic [SELW-1:0]  sel_q;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    dcnt;
    logic             load, sel_chg, abort, last_px, scan;

    logic [XW-1:0]    px [ROM_LAT];
    logic [YW-1:0]    py [ROM_LAT];
    logic [ROM_LAT-1:0] pv, pl;

    logic [XW-1:0]    hx;
    logic [YW-1:0]    hy;
    logic [CW-1:0]    hc;
    logic [CW-1:0]    rom_w [NIMG];
    logic [CW-1:0]    slice;
    logic             live, keyed, done_q;

    for (genvar k = 0; k < NIMG; k++) begin : g_slice
        assign rom_w[k] = iRomData[k*CW +: CW];
    end

    assign sel_chg = (iSel != sel_q);
    assign scan    = (state == SCAN);
    assign abort   = sel_chg && (state != IDLE);
    assign last_px = (x == XMAX) && (y == YMAX);

    always_comb begin
        slice = '0;
        if (int'(sel_q) < NIMG) slice = rom_w[sel_q];
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (iStart || sel_chg || CONTINUOUS != 0) begin
                    state_d = SCAN;
                    load    = 1'b1;
                end
            end
            SCAN: begin
                if (sel_chg) begin
                    load = 1'b1;
                end else if (last_px) begin
                    if (CONTINUOUS != 0) load = 1'b1;
                    else                 state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (sel_chg) begin
                    state_d = SCAN;
                    load    = 1'b1;
                end else if (dcnt == DMAX) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Raster counters; address is a running count rather than y*WIDTH+x
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            x     <= '0;
            y     <= '0;
            addr  <= '0;
            sel_q <= '0;
            dcnt  <= '0;
        end else begin
            if (load) begin
                x     <= '0;
                y     <= '0;
                addr  <= '0;
                sel_q <= iSel;
            end else if (scan) begin
                addr <= addr + AW'(1);
                if (x == XMAX) begin
                    x <= '0;
                    y <= (y == YMAX) ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
            dcnt <= (state == DRAIN) ? dcnt + DW'(1) : '0;
        end
    end

    // Coordinates travel alongside the ROM read so they meet its data
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            pv <= '0;
            pl <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                px[i] <= '0;
                py[i] <= '0;
            end
        end else begin
            px[0] <= x;
            py[0] <= y;
            pl[0] <= last_px;
            pv[0] <= scan && !abort;
            for (int i = ROM_LAT - 1; i > 0; i--) begin
                px[i] <= px[i-1];
                py[i] <= py[i-1];
                pl[i] <= pl[i-1];
                pv[i] <= pv[i-1] && !abort;
            end
        end
    end

    // A pending select change suppresses the tail pixel of the old image
    assign live  = pv[ROM_LAT-1] && !sel_chg;
    assign keyed = iKeyEn && (slice == CW'(KEY_COLOUR));

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            hx     <= '0;
            hy     <= '0;
            hc     <= '0;
            done_q <= 1'b0;
        end else begin
            if (live) begin
                hx <= px[ROM_LAT-1];
                hy <= py[ROM_LAT-1];
                hc <= slice;
            end
            done_q <= live && pl[ROM_LAT-1];
        end
    end

    assign oAddr   = addr;
    assign oX      = live ? px[ROM_LAT-1] : hx;
    assign oY      = live ? py[ROM_LAT-1] : hy;
    assign oColour = live ? slice : hc;
    assign oPlot   = live && !keyed;
    assign oBusy   = (state != IDLE);
    assign oDone   = done_q;

endmodule
